regfile_wb_scheduler: RTL and testbench

- Shares the single write port of the 32x32 register file between the in-order pipeline writeback (WB) and a multi-cycle execution unit (MC, e.g. mul/div).
- Keeps a per-register pending scoreboard for MC operations in flight.
- Raises a decode stall on RAW/WAW hazards against pending registers, when the outstanding-op limit is reached, and to break MC writeback starvation.
- Sits between the WB stage, the MC unit and the register file write port.

---
 rtl/regfile_wb_scheduler.sv | 96 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port between pipeline writeback and a multi-cycle unit
//
// Ports:
//   CLK, RESET_N                  clock (rising edge), asynchronous active-low reset
//   wb_valid/wb_rd/wb_data        pipeline writeback request (highest priority, never back-pressured)
//   mc_issue/mc_issue_rd          MC op dispatched this cycle and its destination
//   mc_valid/mc_rd/mc_data        MC result offered; mc_ready says it was taken this cycle
//   dec_valid/dec_rs1/dec_rs2/
//   dec_rd/dec_is_mc              instruction in decode, checked against the scoreboard
//   stall                         hold decode/fetch
//   rf_we/rf_waddr/rf_wdata       register file write port
//   busy_mask                     per-register pending scoreboard (bit 0 never set)
//   err                           sticky protocol-error flag
module regfile_wb_scheduler #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_rd,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_is_mc,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy_mask,
    output logic        err
);
    localparam logic [3:0] maxCnt    = 4'(MAX_OUTSTANDING);
    localparam logic [7:0] starveMax = 8'(STARVE_LIMIT);

    logic [31:0] busyMask, setMask, clrMask;
    logic [3:0]  outCnt, outCntNext;
    logic [7:0]  starveCnt, starveCntNext;
    logic        starveStall, starveStallNext;
    logic        errReg, errNow, mcAccept, cntFull, cntEmpty;

    assign mc_ready  = !wb_valid;
    assign mcAccept  = mc_valid & mc_ready;
    assign rf_we     = wb_valid | mc_valid;
    assign rf_waddr  = wb_valid ? wb_rd : mc_rd;
    assign rf_wdata  = wb_valid ? wb_data : mc_data;
    assign busy_mask = busyMask;
    assign err       = errReg;
    assign cntFull   = outCnt == maxCnt;
    assign cntEmpty  = outCnt == 4'd0;

    // busyMask[0] is held at zero, so indexing with x0 never reports a hazard.
    // A register being retired this cycle still reads busy: no bypass.
    assign stall = starveStall | (dec_valid & (busyMask[dec_rs1] | busyMask[dec_rs2] |
                   busyMask[dec_rd] | (dec_is_mc & cntFull)));

    always_comb begin
        setMask = (mc_issue ? 32'd1 << mc_issue_rd : 32'd0) & ~32'd1;
        clrMask = mcAccept ? 32'd1 << mc_rd : 32'd0;
        // Issue and accept together cancel; otherwise the count saturates at both ends.
        outCntNext = (mc_issue == mcAccept) ? outCnt :
                     mc_issue ? (cntFull ? outCnt : outCnt + 4'd1) :
                     (cntEmpty ? outCnt : outCnt - 4'd1);
        // mc_valid without wb_valid is an accept, so anything but contention clears the count.
        starveCntNext = !(mc_valid & wb_valid) ? 8'd0 :
                        (starveCnt == starveMax) ? starveCnt : starveCnt + 8'd1;
        starveStallNext = !mcAccept & (starveStall | (starveCntNext == starveMax));
        errNow = (mcAccept & cntEmpty) | (mc_issue & cntFull) |
                 (wb_valid & busyMask[wb_rd]) | (mc_issue & busyMask[mc_issue_rd]);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            busyMask    <= '0;
            outCnt      <= '0;
            starveCnt   <= '0;
            starveStall <= 1'b0;
            errReg      <= 1'b0;
        end else begin
            // Set applied after clear so a same-register issue wins over retirement.
            busyMask    <= (busyMask & ~clrMask) | setMask;
            outCnt      <= outCntNext;
            starveCnt   <= starveCntNext;
            starveStall <= starveStallNext;
            errReg      <= errReg | errNow;
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: self-checking bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
    localparam int MAXO = 4;
    localparam int LIM  = 8;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        wb_valid, mc_issue, mc_valid, dec_valid, dec_is_mc;
    logic [4:0]  wb_rd, mc_issue_rd, mc_rd, dec_rs1, dec_rs2, dec_rd;
    logic [31:0] wb_data, mc_data;
    logic        mc_ready, stall, rf_we, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, busy_mask;

    regfile_wb_scheduler #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_is_mc(dec_is_mc), .stall(stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .err(err)
    );

    always #5 CLK = ~CLK;

    int nAssert = 0;
    int nFail = 0;

    bit mBusy[32];
    int mCnt, mStarve;
    bit mStarveStall, mErr;

    typedef struct {
        logic        wbV;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        logic        mcV;
        logic [4:0]  mcRd;
        logic [31:0] mcData;
        logic        expWe;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic        expReady;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        foreach (mBusy[i]) mBusy[i] = 1'b0;
        mCnt = 0;
        mStarve = 0;
        mStarveStall = 1'b0;
        mErr = 1'b0;
    endtask

    function automatic logic [31:0] mBusyVec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mBusy[i];
        return v;
    endfunction

    function automatic bit mStall();
        return mStarveStall || (dec_valid && ((dec_rs1 != 0 && mBusy[dec_rs1]) ||
               (dec_rs2 != 0 && mBusy[dec_rs2]) || (dec_rd != 0 && mBusy[dec_rd]) ||
               (dec_is_mc && mCnt == MAXO)));
    endfunction

    task automatic modelEdge();
        bit acc, e;
        acc = mc_valid && !wb_valid;
        e = (acc && mCnt == 0) || (mc_issue && mCnt == MAXO) ||
            (wb_valid && mBusy[wb_rd]) || (mc_issue && mBusy[mc_issue_rd]);
        if (mc_issue && !acc) mCnt = (mCnt == MAXO) ? mCnt : mCnt + 1;
        if (acc && !mc_issue) mCnt = (mCnt == 0) ? 0 : mCnt - 1;
        if (acc) mBusy[mc_rd] = 1'b0;
        if (mc_issue && mc_issue_rd != 0) mBusy[mc_issue_rd] = 1'b1;
        mErr = mErr || e;
        mStarve = (mc_valid && wb_valid) ? ((mStarve == LIM) ? LIM : mStarve + 1) : 0;
        if (acc) mStarveStall = 1'b0;
        else if (mStarve == LIM) mStarveStall = 1'b1;
    endtask

    task automatic compareAll();
        check("rf_we", rf_we, wb_valid | mc_valid);
        check("rf_waddr", rf_waddr, wb_valid ? wb_rd : mc_rd);
        check("rf_wdata", rf_wdata, wb_valid ? wb_data : mc_data);
        check("mc_ready", mc_ready, !wb_valid);
        check("stall", stall, mStall());
        check("busy_mask", busy_mask, mBusyVec());
        check("err", err, mErr);
    endtask

    task automatic clearIn();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        mc_issue = 0; mc_issue_rd = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_is_mc = 0;
    endtask

    task automatic cycle();
        #1;
        compareAll();
        @(posedge CLK);
        if (RESET_N) modelEdge();
        #1;
    endtask

    task automatic doReset();
        RESET_N = 1'b0;
        modelReset();
        clearIn();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 32'h12345678, 1'b1};
        vecs[2] = '{1'b1, 5'd3, 32'hAAAA5555, 1'b1, 5'd4, 32'h1111,     1'b1, 5'd3, 32'hAAAA5555, 1'b0};
        vecs[3] = '{1'b0, 5'd7, 32'h77,       1'b0, 5'd8, 32'h88,       1'b0, 5'd8, 32'h88,       1'b1};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd2, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0};
        vecs[5] = '{1'b0, 5'd1, 32'h1,        1'b1, 5'd0, 32'hCAFE,     1'b1, 5'd0, 32'hCAFE,     1'b1};

        RESET_N = 1'b0;
        modelReset();
        clearIn();
        // Arbitration is combinational, so the table runs while held in reset.
        for (int i = 0; i < 6; i++) begin
            wb_valid = vecs[i].wbV; wb_rd = vecs[i].wbRd; wb_data = vecs[i].wbData;
            mc_valid = vecs[i].mcV; mc_rd = vecs[i].mcRd; mc_data = vecs[i].mcData;
            #1;
            check("tbl_we", rf_we, vecs[i].expWe);
            check("tbl_addr", rf_waddr, vecs[i].expAddr);
            check("tbl_data", rf_wdata, vecs[i].expData);
            check("tbl_ready", mc_ready, vecs[i].expReady);
            check("tbl_stall", stall, 1'b0);
            check("tbl_busy", busy_mask, 32'h0);
            check("tbl_err", err, 1'b0);
        end
        clearIn();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Plain writeback
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        #2;
        check("wb_we", rf_we, 1'b1);
        check("wb_addr", rf_waddr, 5'd5);
        check("wb_data", rf_wdata, 32'hDEADBEEF);
        check("wb_ready", mc_ready, 1'b0);
        check("wb_stall", stall, 1'b0);
        cycle();

        // RAW on a pending MC destination, retired the next cycle
        clearIn(); mc_issue = 1; mc_issue_rd = 7;
        cycle();
        clearIn(); dec_valid = 1; dec_rs1 = 7; mc_valid = 1; mc_rd = 7; mc_data = 32'h12;
        #2;
        check("raw_busy", busy_mask, 32'h80);
        check("raw_stall", stall, 1'b1);
        check("raw_waddr", rf_waddr, 5'd7);
        check("raw_wdata", rf_wdata, 32'h12);
        cycle();
        clearIn(); dec_valid = 1; dec_rs1 = 7;
        #2;
        check("raw_clear_busy", busy_mask, 32'h0);
        check("raw_clear_stall", stall, 1'b0);
        cycle();

        // Outstanding limit
        for (int r = 1; r <= 4; r++) begin
            clearIn(); mc_issue = 1; mc_issue_rd = 5'(r);
            cycle();
        end
        clearIn(); dec_valid = 1; dec_is_mc = 1; dec_rs1 = 10; dec_rs2 = 11; dec_rd = 12;
        mc_valid = 1; mc_rd = 1; mc_data = 32'h1;
        #2;
        check("full_stall", stall, 1'b1);
        cycle();
        clearIn(); dec_valid = 1; dec_is_mc = 1; dec_rs1 = 10; dec_rs2 = 11; dec_rd = 12;
        #2;
        check("full_release", stall, 1'b0);
        cycle();

        // MC starvation behind continuous writeback
        clearIn(); wb_valid = 1; wb_rd = 20; wb_data = 32'h2020; mc_valid = 1; mc_rd = 2; mc_data = 32'h22;
        for (int k = 0; k < LIM; k++) begin
            #2;
            check("starve_early", stall, 1'b0);
            cycle();
        end
        #2;
        check("starve_stall", stall, 1'b1);
        wb_valid = 0;
        #1;
        check("starve_hold", stall, 1'b1);
        check("starve_accept", mc_ready, 1'b1);
        cycle();
        clearIn();
        #2;
        check("starve_release", stall, 1'b0);
        check("starve_err", err, 1'b0);
        cycle();

        // Same-register issue and retire: set wins, count unchanged
        clearIn(); mc_issue = 1; mc_issue_rd = 9; mc_valid = 1; mc_rd = 9; mc_data = 32'h99;
        cycle();
        clearIn();
        #2;
        check("setwin_busy", busy_mask, 32'h218);
        clearIn(); mc_issue = 1; mc_issue_rd = 10;
        cycle();
        clearIn(); mc_issue = 1; mc_issue_rd = 11;
        cycle();
        clearIn(); dec_valid = 1; dec_is_mc = 1; dec_rs1 = 20;
        #2;
        check("setwin_count", stall, 1'b1);
        check("setwin_mask", busy_mask, 32'hE18);
        check("setwin_err", err, 1'b0);
        cycle();

        // Accept at count 0, sticky err, async reset mid-flight
        doReset();
        mc_valid = 1; mc_rd = 5; mc_data = 32'h55;
        cycle();
        clearIn();
        #2;
        check("underflow_err", err, 1'b1);
        cycle();
        cycle();
        #2;
        check("err_sticky", err, 1'b1);
        for (int r = 1; r <= 4; r++) begin
            clearIn(); mc_issue = 1; mc_issue_rd = 5'(r);
            cycle();
        end
        clearIn(); dec_valid = 1; dec_rs1 = 1;
        #2;
        check("pre_reset_busy", busy_mask, 32'h1E);
        #1;
        RESET_N = 1'b0;
        modelReset();
        #1;
        check("async_busy", busy_mask, 32'h0);
        check("async_err", err, 1'b0);
        check("async_stall", stall, 1'b0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            mc_issue = ($urandom_range(0, 3) == 0);
            mc_issue_rd = 5'($urandom_range(0, 7));
            mc_valid = ($urandom_range(0, 2) == 0);
            mc_rd = 5'($urandom_range(0, 7)); mc_data = $urandom;
            dec_valid = $urandom_range(0, 1) == 1;
            dec_rs1 = 5'($urandom_range(0, 7)); dec_rs2 = 5'($urandom_range(0, 7));
            dec_rd = 5'($urandom_range(0, 7)); dec_is_mc = $urandom_range(0, 1) == 1;
            if (n % 100 == 99) begin
                RESET_N = 1'b0;
                modelReset();
            end
            cycle();
            RESET_N = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
